// File: rtl/shift_right_unit.sv
// Iterative right-shift unit: logical, arithmetic and (optionally) rotate, one bit per clock.
// Rotate is built only when SHIFT_RIGHT_ROTATE_EN is defined; otherwise mode 10 is a logical shift.
module shift_right_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in,
  input  logic [AMT_W-1:0]  amt,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_LSR,
    OP_ASR,
    OP_ROR
  } op_t;

  state_t            r_state, w_state_nxt;
  op_t               r_op, w_op_nxt, w_op_dec;
  logic [DATA_W-1:0] r_work, w_work_nxt;
  logic [DATA_W-1:0] r_out, w_out_nxt;
  logic [AMT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_msb, w_msb_nxt;
  logic              w_fill;

  always_comb begin
    w_op_dec = OP_LSR;
    case (mode)
      2'b01:   w_op_dec = OP_ASR;
`ifdef SHIFT_RIGHT_ROTATE_EN
      2'b10:   w_op_dec = OP_ROR;
`endif
      default: w_op_dec = OP_LSR;
    endcase
  end

  // Bit entering the MSB on each shift step.
  always_comb begin
    w_fill = 1'b0;
    case (r_op)
      OP_ASR:  w_fill = r_msb;
`ifdef SHIFT_RIGHT_ROTATE_EN
      OP_ROR:  w_fill = r_work[0];
`endif
      default: w_fill = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_msb_nxt   = r_msb;
    w_out_nxt   = r_out;
    case (r_state)
      S_SHIFT: begin
        w_work_nxt = {w_fill, r_work[DATA_W-1:1]};
        w_cnt_nxt  = r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          w_work_nxt  = in;
          w_cnt_nxt   = amt;
          w_op_nxt    = w_op_dec;
          w_msb_nxt   = in[DATA_W-1];
          w_state_nxt = (amt == '0) ? S_DONE : S_SHIFT;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // out is loaded on the same edge that enters DONE, from the value the work register takes.
    if (w_state_nxt == S_DONE) begin
      w_out_nxt = w_work_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_LSR;
      r_work  <= '0;
      r_cnt   <= '0;
      r_msb   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_msb   <= w_msb_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign out  = r_out;
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule
